// File: rtl/reg_bus_pkg.sv
// Shared types and helpers for the register-bus sequencer.
package reg_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2
    } state_t;

    // True when a captured index addresses an existing cell.
    function automatic logic idx_ok(input logic [31:0] idx, input logic [31:0] nregs);
        return idx < nregs;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    int   pos;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(ptr) + k) % NREQ;
            if (en && !found && req[pos]) begin
                found          = 1'b1;
                grant[pos]     = 1'b1;
                grant_idx      = pos[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_bus_ctrl.sv
// Arbitrates move requests and sequences the bank's drive/latch enables
// as IDLE -> DRIVE -> LATCH, one move at a time.
module reg_bus_ctrl
    import reg_bus_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int NREQ  = 2,
    localparam int IDXW = $clog2(NREGS),
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*IDXW-1:0] req_src,
    input  logic [NREQ*IDXW-1:0] req_dst,
    output logic [NREQ-1:0]      req_done,
    output logic                 req_err,
    output logic [NREGS-1:0]     out_use,
    output logic [NREGS-1:0]     in_use,
    output logic                 busy
);

    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    state_t          state, state_nxt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id;
    logic [IDXW-1:0] src, dst;
    logic            bad;
    logic [IDXW-1:0] sel_src, sel_dst;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            idle;

    assign idle    = (state == IDLE);
    assign sel_src = req_src[int'(grant_idx)*IDXW +: IDXW];
    assign sel_dst = req_dst[int'(grant_idx)*IDXW +: IDXW];

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .en        (idle),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (state == LATCH)
                ptr <= (id == LAST_ID) ? '0 : id + IDW'(1);
        end
    end

    // Capture registers hold the granted move; request inputs are ignored
    // outside IDLE so the move cannot be disturbed once started.
    always_ff @(posedge clk) begin
        if (idle && |grant) begin
            id  <= grant_idx;
            src <= sel_src;
            dst <= sel_dst;
            bad <= !(idx_ok(32'(sel_src), 32'(NREGS)) && idx_ok(32'(sel_dst), 32'(NREGS)));
        end
    end

    always_comb begin
        state_nxt = state;
        out_use   = '0;
        in_use    = '0;
        req_done  = '0;
        req_err   = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (|grant)
                    state_nxt = DRIVE;
            end
            DRIVE: begin
                state_nxt = LATCH;
                if (!bad)
                    out_use[src] = 1'b1;
            end
            LATCH: begin
                state_nxt = IDLE;
                if (!bad) begin
                    out_use[src] = 1'b1;
                    in_use[dst]  = 1'b1;
                end
                req_done[id] = 1'b1;
                req_err      = bad;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
